// File: rtl/apb_regbank_slave.sv
// APB completer with a bank of 16-bit registers, programmable wait states and
// decode / write-protection error reporting. Register 0 is a read-only ID,
// register 1 is exported as the datapath control word.
module apb_regbank_slave #(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [15:0] ID_VALUE    = 16'hA5C3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [15:0] PADDR,
   input  logic [2:0]  PPROT,
   input  logic [15:0] PWDATA,
   output logic [15:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [15:0] CTRL
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] prdata_q, prdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic        wr_en;

   // Register 0 is the constant ID, so storage starts at index 1.
   logic [15:0] regs_q [1:DEPTH-1];

   logic          hit;
   logic [AW-1:0] idx;
   logic [15:0]   rd_val;

   // Protection attributes are accepted but have no effect.
   logic unused_pprot;
   assign unused_pprot = ^PPROT;

   // Full 16-bit compare: any set upper bit makes the access a miss.
   assign hit = (32'(PADDR) < DEPTH);
   assign idx = PADDR[AW-1:0];

   // Read mux over the bank, with the ID word at index 0.
   always_comb begin
      rd_val = ID_VALUE;
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (idx == AW'(i)) begin
            rd_val = regs_q[i];
         end
      end
   end

   // Next-state and response decode; responses are captured on WAIT->DONE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prdata_d  = prdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         StIdle: begin
            if (PSEL && PENABLE) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         StWait: begin
            if (!PSEL || !PENABLE) begin
               // Initiator gave up: drop the transfer silently.
               state_d = StIdle;
            end else if (cnt_q == 4'd0) begin
               state_d  = StDone;
               pready_d = 1'b1;
               if (PWRITE) begin
                  if (hit && (idx != '0)) begin
                     wr_en = 1'b1;
                  end else begin
                     pslverr_d = 1'b1;
                  end
               end else if (hit) begin
                  prdata_d = rd_val;
               end else begin
                  prdata_d  = 16'h0000;
                  pslverr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            // No new transfer is recognised here; a following setup phase is harmless.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM, wait counter and registered response outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         prdata_q  <= 16'h0000;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
      end
   end

   // Register bank write port.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 1; i < int'(DEPTH); i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else if (wr_en) begin
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (idx == AW'(i)) begin
               regs_q[i] <= PWDATA;
            end
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign CTRL    = regs_q[1];

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: three builds (WAIT_CYCLES 0, 1, 15) on a
// shared bus, each with its own PSEL. Inputs change on the falling edge.
module tb_apb_regbank_slave;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        PENABLE, PWRITE;
   logic [15:0] PADDR, PWDATA;
   logic [2:0]  PPROT;
   logic        psel    [3];
   logic [15:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];
   logic [15:0] ctrl    [3];

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] rd, cd;
   logic        er;
   int          lat;

   always #5 CLK = ~CLK;

   // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1, index 2: WAIT_CYCLES=15.
   apb_regbank_slave #(.DEPTH(32), .WAIT_CYCLES(0), .ID_VALUE(16'hA5C3)) u_dut0 (
      .CLK(CLK), .RESET(RESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]), .CTRL(ctrl[0])
   );

   apb_regbank_slave #(.DEPTH(32), .WAIT_CYCLES(1), .ID_VALUE(16'hA5C3)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]), .CTRL(ctrl[1])
   );

   apb_regbank_slave #(.DEPTH(32), .WAIT_CYCLES(15), .ID_VALUE(16'hA5C3)) u_dut15 (
      .CLK(CLK), .RESET(RESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(prdata[2]),
      .PREADY(pready[2]), .PSLVERR(pslverr[2]), .CTRL(ctrl[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One APB transfer starting at a falling edge. lat counts falling edges after
   // PENABLE rises, so lat == k means PREADY was high in cycle T0+k.
   task automatic apb_xfer(input int inst, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rdata,
                           output logic err, output int lat_o, output logic [15:0] ctrl_o);
      psel[inst] = 1'b1;
      PENABLE    = 1'b0;
      PWRITE     = wr;
      PADDR      = addr;
      PWDATA     = wdata;
      @(negedge CLK);
      check_eq("no_pready_in_setup", 32'(pready[inst]), 32'd0);
      PENABLE = 1'b1;
      lat_o   = 0;
      while (lat_o < 40) begin
         @(negedge CLK);
         lat_o++;
         if (pready[inst] === 1'b1) break;
      end
      check_eq("pready_seen", 32'(pready[inst]), 32'd1);
      rdata      = prdata[inst];
      err        = pslverr[inst];
      ctrl_o     = ctrl[inst];
      psel[inst] = 1'b0;
      PENABLE    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      RESET   = 1'b0;
      psel[0] = 1'b0;
      psel[1] = 1'b0;
      psel[2] = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = 16'h0000;
      PWDATA  = 16'h0000;
      PPROT   = 3'b010;
      repeat (3) @(negedge CLK);
      check_eq("rst_pready", 32'(pready[1]), 32'd0);
      check_eq("rst_pslverr", 32'(pslverr[1]), 32'd0);
      check_eq("rst_prdata", 32'(prdata[1]), 32'h0);
      check_eq("rst_ctrl", 32'(ctrl[1]), 32'h0);
      RESET = 1'b1;
      @(negedge CLK);

      // ID read, one wait state: PREADY in T0+3, one cycle wide.
      apb_xfer(1, 1'b0, 16'd0, 16'h0, rd, er, lat, cd);
      check_eq("id_lat", 32'(lat), 32'd3);
      check_eq("id_data", 32'(rd), 32'hA5C3);
      check_eq("id_err", 32'(er), 32'd0);
      @(negedge CLK);
      check_eq("id_pready_width", 32'(pready[1]), 32'd0);

      // Control word write, visible on CTRL in the DONE cycle, then readback.
      apb_xfer(1, 1'b1, 16'd1, 16'h1234, rd, er, lat, cd);
      check_eq("wr1_err", 32'(er), 32'd0);
      check_eq("wr1_ctrl_done", 32'(cd), 32'h1234);
      @(negedge CLK);
      apb_xfer(1, 1'b0, 16'd1, 16'h0, rd, er, lat, cd);
      check_eq("rd1_data", 32'(rd), 32'h1234);
      check_eq("rd1_err", 32'(er), 32'd0);
      @(negedge CLK);

      // Error cases: protected ID write, read miss, upper-bit write miss.
      apb_xfer(1, 1'b1, 16'd0, 16'hFFFF, rd, er, lat, cd);
      check_eq("wr0_err", 32'(er), 32'd1);
      @(negedge CLK);
      check_eq("err_cleared", 32'(pslverr[1]), 32'd0);
      apb_xfer(1, 1'b0, 16'd32, 16'h0, rd, er, lat, cd);
      check_eq("rdmiss_err", 32'(er), 32'd1);
      check_eq("rdmiss_data", 32'(rd), 32'h0);
      @(negedge CLK);
      apb_xfer(1, 1'b1, 16'h0200, 16'h5555, rd, er, lat, cd);
      check_eq("wrmiss_err", 32'(er), 32'd1);
      check_eq("wrmiss_prdata_hold", 32'(rd), 32'h0);
      check_eq("wrmiss_ctrl", 32'(cd), 32'h1234);
      @(negedge CLK);
      apb_xfer(1, 1'b0, 16'd0, 16'h0, rd, er, lat, cd);
      check_eq("id_after_wr", 32'(rd), 32'hA5C3);
      check_eq("id_after_wr_err", 32'(er), 32'd0);
      @(negedge CLK);

      // Zero and maximum wait-state builds.
      apb_xfer(0, 1'b0, 16'd0, 16'h0, rd, er, lat, cd);
      check_eq("w0_lat", 32'(lat), 32'd2);
      check_eq("w0_data", 32'(rd), 32'hA5C3);
      @(negedge CLK);
      check_eq("w0_pready_width", 32'(pready[0]), 32'd0);
      apb_xfer(2, 1'b0, 16'd0, 16'h0, rd, er, lat, cd);
      check_eq("w15_lat", 32'(lat), 32'd17);
      check_eq("w15_data", 32'(rd), 32'hA5C3);
      @(negedge CLK);
      check_eq("w15_pready_width", 32'(pready[2]), 32'd0);

      // Back-to-back: the read's setup phase lands in the write's DONE cycle.
      apb_xfer(1, 1'b1, 16'd5, 16'h00AA, rd, er, lat, cd);
      check_eq("b2b_wr_err", 32'(er), 32'd0);
      apb_xfer(1, 1'b0, 16'd5, 16'h0, rd, er, lat, cd);
      check_eq("b2b_rd_lat", 32'(lat), 32'd3);
      check_eq("b2b_rd_data", 32'(rd), 32'h00AA);
      @(negedge CLK);
      check_eq("b2b_pready_width", 32'(pready[1]), 32'd0);

      // Abort: PSEL drops while in WAIT, write to 3 must not land.
      psel[1] = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = 16'd3;
      PWDATA  = 16'hBEEF;
      PENABLE = 1'b0;
      @(negedge CLK);
      PENABLE = 1'b1;
      @(negedge CLK);
      psel[1] = 1'b0;
      PENABLE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check_eq("abort_no_pready", 32'(pready[1]), 32'd0);
      end
      apb_xfer(1, 1'b0, 16'd3, 16'h0, rd, er, lat, cd);
      check_eq("abort_rd3", 32'(rd), 32'h0);
      check_eq("abort_rd3_lat", 32'(lat), 32'd3);
      @(negedge CLK);

      // Reset while in WAIT on a write to 4.
      psel[1] = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = 16'd4;
      PWDATA  = 16'hCAFE;
      PENABLE = 1'b0;
      @(negedge CLK);
      PENABLE = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check_eq("rst_mid_pready", 32'(pready[1]), 32'd0);
      check_eq("rst_mid_ctrl", 32'(ctrl[1]), 32'h0);
      psel[1] = 1'b0;
      PENABLE = 1'b0;
      @(negedge CLK);
      check_eq("rst_hold_pready", 32'(pready[1]), 32'd0);
      RESET = 1'b1;
      @(negedge CLK);
      apb_xfer(1, 1'b0, 16'd4, 16'h0, rd, er, lat, cd);
      check_eq("rst_rd4", 32'(rd), 32'h0);
      check_eq("rst_rd4_lat", 32'(lat), 32'd3);
      @(negedge CLK);
      apb_xfer(1, 1'b0, 16'd1, 16'h0, rd, er, lat, cd);
      check_eq("rst_rd1", 32'(rd), 32'h0);
      check_eq("rst_ctrl_after", 32'(cd), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
